pcm_tdm_ser: RTL and testbench

- Parametrised multi-channel TDM PCM serializer. Successor to the single-channel 8-bit PCM encoder.
- Accepts one full frame (NUM_CH samples of DATA_W bits) over a valid/ready handshake and buffers it in a one-frame holding register.
- Shifts the frame out MSB-first, channel 0 first, at a programmable bit rate, with frame sync and slot strobes.
- Sits between the sample source and the line encoder (HDB3 path). The line encoder consumes ser_out qualified by bit_en.

---
 rtl/pcm_tdm_pkg.sv | 26 ++
 rtl/pcm_bit_div.sv | 32 +++
 rtl/pcm_tdm_ser.sv | 216 +++++++++++++++++++++
 tb/tb_pcm_tdm_ser.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcm_tdm_pkg.sv
// Shared types and sizing helpers for the TDM PCM serializer and its receiver.
// PCM_TDM_PARITY_EN adds an even-parity bit after each channel sample.
package pcm_tdm_pkg;

`ifdef PCM_TDM_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  // Bits per channel slot on the line.
  function automatic int unsigned slot_w(input int unsigned data_w, input bit parity);
    return parity ? data_w + 1 : data_w;
  endfunction

  // Index width for a counter over n values; never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/pcm_bit_div.sv
// Serial bit-rate tick generator: one tick every DIV clocks while enabled.
// Shared by the TDM serializer and receiver.
module pcm_bit_div
  import pcm_tdm_pkg::*;
#(
  parameter int unsigned DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick_c
);

  localparam int unsigned           CNT_W   = idx_w(DIV);
  localparam logic [CNT_W-1:0]      CNT_MAX = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= (r_cnt == CNT_MAX) ? '0 : r_cnt + CNT_W'(1);
    end
  end

  assign o_tick_c = i_en && (r_cnt == CNT_MAX);

endmodule

// File: rtl/pcm_tdm_ser.sv
// Multi-channel TDM PCM serializer: one-frame holding register, MSB-first shifter,
// frame/slot strobes and underrun fill. PCM_TDM_PARITY_EN appends even parity per slot.
module pcm_tdm_ser
  import pcm_tdm_pkg::*;
#(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned CLK_DIV = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [NUM_CH*DATA_W-1:0]   s_data,
  output logic                       ser_out,
  output logic                       bit_en,
  output logic                       frame_sync,
  output logic                       slot_start,
  output logic [idx_w(NUM_CH)-1:0]   ch_idx,
  output logic                       underrun,
  output logic                       busy
);

  localparam int unsigned FRAME_W = NUM_CH * DATA_W;
  localparam int unsigned SLOT_W  = slot_w(DATA_W, PARITY_EN);
  localparam int unsigned CH_W    = idx_w(NUM_CH);
  localparam int unsigned BIT_W   = idx_w(SLOT_W);

  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(SLOT_W - 1);
  localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);

  state_e               r_state, nxt_state;
  logic [FRAME_W-1:0]   r_hold, nxt_hold;
  logic                 r_empty, nxt_empty;
  logic [FRAME_W-1:0]   r_shift, nxt_shift;
  logic [BIT_W-1:0]     r_bit_cnt, nxt_bit_cnt;
  logic [CH_W-1:0]      r_ch_cnt, nxt_ch_cnt;
  logic                 r_ser, nxt_ser;
  logic                 r_bit_en, nxt_bit_en;
  logic                 r_fsync, nxt_fsync;
  logic                 r_slot, nxt_slot;
  logic [CH_W-1:0]      r_ch_idx, nxt_ch_idx;
  logic                 r_under, nxt_under;
  logic                 r_busy, nxt_busy;
`ifdef PCM_TDM_PARITY_EN
  logic                 r_par, nxt_par;
`endif

  logic                 w_run;
  logic                 w_tick;
  logic                 w_take;
  logic                 w_last_bit;
  logic                 w_last_ch;
  logic [FRAME_W-1:0]   w_ord;

  assign w_run      = (r_state == ST_RUN);
  assign w_last_bit = (r_bit_cnt == LAST_BIT);
  assign w_last_ch  = (r_ch_cnt == LAST_CH);

  pcm_bit_div #(
    .DIV      (CLK_DIV)
  ) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_en     (w_run),
    .i_clr    (!w_run),
    .o_tick_c (w_tick)
  );

  // Reorder the held frame so channel 0 sits at the shifter MSB end.
  always_comb begin
    w_ord = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      w_ord[(NUM_CH - 1 - k) * DATA_W +: DATA_W] = r_hold[k * DATA_W +: DATA_W];
    end
  end

  always_comb begin
    nxt_state   = r_state;
    nxt_hold    = r_hold;
    nxt_empty   = r_empty;
    nxt_shift   = r_shift;
    nxt_bit_cnt = r_bit_cnt;
    nxt_ch_cnt  = r_ch_cnt;
    nxt_ser     = r_ser;
    nxt_bit_en  = 1'b0;
    nxt_fsync   = 1'b0;
    nxt_slot    = 1'b0;
    nxt_ch_idx  = r_ch_idx;
    nxt_under   = 1'b0;
    nxt_busy    = 1'b0;
    w_take      = 1'b0;
`ifdef PCM_TDM_PARITY_EN
    nxt_par     = r_par;
`endif

    case (r_state)
      ST_IDLE: begin
        nxt_ser    = 1'b0;
        nxt_ch_idx = '0;
        if (enable && !r_empty) begin
          w_take      = 1'b1;
          nxt_state   = ST_RUN;
          nxt_shift   = w_ord;
          nxt_bit_cnt = '0;
          nxt_ch_cnt  = '0;
        end
      end

      ST_RUN: begin
        if (w_tick) begin
          nxt_bit_en = 1'b1;
          nxt_slot   = (r_bit_cnt == '0);
          nxt_fsync  = (r_bit_cnt == '0) && (r_ch_cnt == '0);
          nxt_ch_idx = r_ch_cnt;
`ifdef PCM_TDM_PARITY_EN
          // Last slot position carries the even parity of the sample just sent.
          if (w_last_bit) begin
            nxt_ser = r_par;
          end else begin
            nxt_ser   = r_shift[FRAME_W-1];
            nxt_shift = {r_shift[FRAME_W-2:0], 1'b0};
            nxt_par   = (r_bit_cnt == '0) ? r_shift[FRAME_W-1] : (r_par ^ r_shift[FRAME_W-1]);
          end
`else
          nxt_ser   = r_shift[FRAME_W-1];
          nxt_shift = {r_shift[FRAME_W-2:0], 1'b0};
`endif
          if (w_last_bit) begin
            nxt_bit_cnt = '0;
            nxt_ch_cnt  = w_last_ch ? '0 : r_ch_cnt + CH_W'(1);
          end else begin
            nxt_bit_cnt = r_bit_cnt + BIT_W'(1);
          end

          // Frame boundary: stop, chain the next frame, or fill with silence.
          if (w_last_bit && w_last_ch) begin
            if (!enable) begin
              nxt_state = ST_IDLE;
            end else if (!r_empty) begin
              w_take    = 1'b1;
              nxt_shift = w_ord;
            end else begin
              nxt_shift = '0;
              nxt_under = 1'b1;
            end
          end
        end
      end

      default: nxt_state = ST_IDLE;
    endcase

    if (w_take) begin
      nxt_empty = 1'b1;
    end else if (s_valid && r_empty) begin
      nxt_empty = 1'b0;
      nxt_hold  = s_data;
    end

    nxt_busy = (nxt_state == ST_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_hold    <= '0;
      r_empty   <= 1'b1;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_ch_cnt  <= '0;
      r_ser     <= 1'b0;
      r_bit_en  <= 1'b0;
      r_fsync   <= 1'b0;
      r_slot    <= 1'b0;
      r_ch_idx  <= '0;
      r_under   <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= nxt_state;
      r_hold    <= nxt_hold;
      r_empty   <= nxt_empty;
      r_shift   <= nxt_shift;
      r_bit_cnt <= nxt_bit_cnt;
      r_ch_cnt  <= nxt_ch_cnt;
      r_ser     <= nxt_ser;
      r_bit_en  <= nxt_bit_en;
      r_fsync   <= nxt_fsync;
      r_slot    <= nxt_slot;
      r_ch_idx  <= nxt_ch_idx;
      r_under   <= nxt_under;
      r_busy    <= nxt_busy;
    end
  end

`ifdef PCM_TDM_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_par <= 1'b0;
    end else begin
      r_par <= nxt_par;
    end
  end
`endif

  assign s_ready    = r_empty;
  assign ser_out    = r_ser;
  assign bit_en     = r_bit_en;
  assign frame_sync = r_fsync;
  assign slot_start = r_slot;
  assign ch_idx     = r_ch_idx;
  assign underrun   = r_under;
  assign busy       = r_busy;

endmodule

// File: tb/tb_pcm_tdm_ser.sv
// Bench for pcm_tdm_ser: two instances (1 and 4 clocks per bit), expected bit
// streams queued at frame acceptance and compared on each bit strobe.
module tb_pcm_tdm_ser;

  localparam int unsigned CLK_P = 10;
`ifdef PCM_TDM_PARITY_EN
  localparam int unsigned SLOT = 9;
`else
  localparam int unsigned SLOT = 8;
`endif
  localparam int unsigned FB = 2 * SLOT;

  typedef struct packed {
    logic ser;
    logic fs;
    logic ss;
    logic ch;
  } exp_t;

  typedef struct {
    logic [7:0]  ch0;
    logic [7:0]  ch1;
    logic [15:0] stream;
    logic [1:0]  par;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        en = 1'b0, sv = 1'b0, sr, ser, ben, fs, ss, ur, busy;
  logic [15:0] sd = '0;
  logic [0:0]  ch;

  logic        en4 = 1'b0, sv4 = 1'b0, sr4, ser4, ben4, fs4, ss4, ur4, busy4;
  logic [15:0] sd4 = '0;
  logic [0:0]  ch4;

  int          n_checks = 0;
  int          n_fail = 0;
  int          n_bits = 0;
  int          n4 = 0;
  int          n_under = 0;
  int          n_rdy_rise = 0;
  time         t_under = 0;
  time         bit_t[0:1023];
  time         t4[0:1023];
  exp_t        q[$];
  exp_t        q4[$];
  vec_t        tbl[4];

  always #(CLK_P/2) clk = ~clk;

  pcm_tdm_ser #(.DATA_W(8), .NUM_CH(2), .CLK_DIV(1)) dut (
    .clk(clk), .rst_n(rst_n), .enable(en), .s_valid(sv), .s_ready(sr), .s_data(sd),
    .ser_out(ser), .bit_en(ben), .frame_sync(fs), .slot_start(ss), .ch_idx(ch),
    .underrun(ur), .busy(busy)
  );

  pcm_tdm_ser #(.DATA_W(8), .NUM_CH(2), .CLK_DIV(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .enable(en4), .s_valid(sv4), .s_ready(sr4), .s_data(sd4),
    .ser_out(ser4), .bit_en(ben4), .frame_sync(fs4), .slot_start(ss4), .ch_idx(ch4),
    .underrun(ur4), .busy(busy4)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm, input int act, input int exp);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  // Queue the expected line bits of one frame {ch0,ch1} MSB-first, parity after each LSB.
  task automatic push_stream(input logic [15:0] st, input logic [1:0] par, input bit to4);
    for (int i = 0; i < 16; i++) begin
      int   c;
      exp_t e;
      c    = i / 8;
      e.ser = st[15-i];
      e.fs  = (i == 0);
      e.ss  = (i % 8 == 0);
      e.ch  = c[0];
      if (to4) q4.push_back(e); else q.push_back(e);
`ifdef PCM_TDM_PARITY_EN
      if (i % 8 == 7) begin
        e.ser = par[c];
        e.fs  = 1'b0;
        e.ss  = 1'b0;
        if (to4) q4.push_back(e); else q.push_back(e);
      end
`endif
    end
  endtask

  task automatic push_frame(input logic [7:0] c0, input logic [7:0] c1);
    push_stream({c0, c1}, {^c1, ^c0}, 1'b0);
  endtask

  // Offer a frame to the CLK_DIV=1 instance; returns 1ns after the accepting edge.
  task automatic send1(input logic [7:0] c0, input logic [7:0] c1, input bit keep, output time t_acc);
    int k;
    k  = 0;
    sd = {c1, c0};
    sv = 1'b1;
    while (!sr && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    if (!sr) fail_now("accept_timeout", 0, 1);
    @(posedge clk);
    t_acc = $time;
    #1;
    if (!keep) sv = 1'b0;
  endtask

  task automatic wait_bits(input int n);
    int k;
    k = 0;
    do begin
      @(posedge clk);
      k++;
    end while (n_bits < n && k < 4000);
    if (n_bits < n) fail_now("bit_timeout", n_bits, n);
    #1;
  endtask

  task automatic mon1();
    exp_t e;
    logic prev_sr;
    prev_sr = 1'b1;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (ben) begin
          bit_t[n_bits[9:0]] = $time;
          n_bits++;
          if (q.size() == 0) begin
            fail_now("extra_bit", n_bits, n_bits - 1);
          end else begin
            e = q.pop_front();
            check("bit", {28'd0, ser, fs, ss, ch[0]}, {28'd0, e});
          end
        end
        if (ur) begin
          n_under++;
          t_under = $time;
        end
        if (sr && !prev_sr) n_rdy_rise++;
      end
      prev_sr = sr;
    end
  endtask

  task automatic mon4();
    exp_t e;
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (ben4) begin
          t4[n4[9:0]] = $time;
          n4++;
          check("ur4", {31'd0, ur4}, 32'd0);
          if (q4.size() == 0) begin
            fail_now("extra_bit4", n4, n4 - 1);
          end else begin
            e = q4.pop_front();
            check("bit4", {28'd0, ser4, fs4, ss4, ch4[0]}, {28'd0, e});
          end
          prev = ser4;
        end else if (busy4) begin
          check("ser_hold4", {31'd0, ser4}, {31'd0, prev});
        end else begin
          prev = ser4;
        end
      end
    end
  endtask

  task automatic main_seq();
    time t_acc, t_b;
    int  base, u0, r0, bad;

    tbl[0] = '{8'hA5, 8'h3C, 16'hA53C, 2'b00};
    tbl[1] = '{8'h07, 8'h80, 16'h0780, 2'b11};
    tbl[2] = '{8'hFF, 8'h00, 16'hFF00, 2'b00};
    tbl[3] = '{8'h01, 8'h80, 16'h0180, 2'b11};

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {31'd0, sr}, 32'd1);
    check("rst_outs", {25'd0, ser, ben, fs, ss, ch[0], ur, busy}, 32'd0);
    check("rst_ready4", {31'd0, sr4}, 32'd1);
    check("rst_outs4", {25'd0, ser4, ben4, fs4, ss4, ch4[0], ur4, busy4}, 32'd0);
    @(negedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Table: single frames from idle, enable withdrawn right after the start
    for (int i = 0; i < 4; i++) begin
      base = n_bits;
      u0   = n_under;
      en   = 1'b1;
      send1(tbl[i].ch0, tbl[i].ch1, 1'b0, t_acc);
      push_stream(tbl[i].stream, tbl[i].par, 1'b0);
      @(posedge clk); #1 en = 1'b0;
      wait_bits(base + FB);
      check("latency", 32'(bit_t[base] - t_acc), 32'(2*CLK_P + CLK_P/2));
      @(posedge clk); #1;
      check("idle_busy", {31'd0, busy}, 32'd0);
      check("no_underrun", 32'(n_under - u0), 32'd0);
    end

    // Back-to-back frames with s_valid held
    base = n_bits; u0 = n_under; r0 = n_rdy_rise;
    en = 1'b1;
    send1(8'h01, 8'h80, 1'b1, t_acc);
    push_frame(8'h01, 8'h80);
    send1(8'hFF, 8'h00, 1'b0, t_b);
    push_frame(8'hFF, 8'h00);
    wait_bits(base + FB + 1);
    en = 1'b0;
    wait_bits(base + 2*FB);
    check("b2b_gap", 32'(bit_t[base+FB] - bit_t[base+FB-1]), 32'(CLK_P));
    check("b2b_underrun", 32'(n_under - u0), 32'd0);
    check("b2b_ready_rises", 32'(n_rdy_rise - r0), 32'd2);

    // Underrun: one frame, then silence with frame timing kept
    @(posedge clk); #1;
    base = n_bits; u0 = n_under;
    en = 1'b1;
    send1(8'h5A, 8'hC3, 1'b0, t_acc);
    push_frame(8'h5A, 8'hC3);
    push_frame(8'h00, 8'h00);
    wait_bits(base + FB + 1);
    en = 1'b0;
    wait_bits(base + 2*FB);
    check("ur_count", 32'(n_under - u0), 32'd1);
    check("ur_time", 32'(t_under - bit_t[base+FB-1]), 32'd0);
    check("ur_gap", 32'(bit_t[base+FB] - bit_t[base+FB-1]), 32'(CLK_P));
    @(posedge clk); #1;
    check("ur_idle", {31'd0, busy}, 32'd0);

    // enable dropped at bit 5: frame completes, then line goes quiet
    base = n_bits;
    en = 1'b1;
    send1(8'h96, 8'h69, 1'b0, t_acc);
    push_frame(8'h96, 8'h69);
    wait_bits(base + 5);
    en = 1'b0;
    wait_bits(base + FB);
    @(posedge clk); #1;
    check("stop_state", {29'd0, busy, ser, ben}, 32'd0);
    repeat (20) @(posedge clk);
    #1;
    check("stop_no_extra", 32'(n_bits), 32'(base + FB));

    // Reset mid-frame
    base = n_bits;
    en = 1'b1;
    send1(8'hF0, 8'h0F, 1'b0, t_acc);
    push_frame(8'hF0, 8'h0F);
    wait_bits(base + 6);
    #3 rst_n = 1'b0;
    #1;
    check("midrst_ready", {31'd0, sr}, 32'd1);
    check("midrst_outs", {25'd0, ser, ben, fs, ss, ch[0], ur, busy}, 32'd0);
    q.delete();
    base = n_bits;
    en = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("midrst_lost", 32'(n_bits), 32'(base));

    // CLK_DIV=4 instance
    en4 = 1'b1;
    sd4 = {8'h3C, 8'hA5};
    sv4 = 1'b1;
    @(posedge clk); #1 sv4 = 1'b0;
    push_stream(16'hA53C, 2'b00, 1'b1);
    @(posedge clk); #1 en4 = 1'b0;
    begin
      int k;
      k = 0;
      while (n4 < FB && k < 1000) begin
        @(posedge clk);
        k++;
      end
      if (n4 < FB) fail_now("div4_timeout", n4, FB);
    end
    bad = 0;
    for (int k = 1; k < FB; k++) begin
      if (t4[k] - t4[k-1] != 4*CLK_P) bad++;
    end
    check("div4_period", 32'(t4[1] - t4[0]), 32'(4*CLK_P));
    check("div4_bad_periods", 32'(bad), 32'd0);
    check("div4_span", 32'(t4[FB-1] - t4[0]), 32'((FB-1)*4*CLK_P));
    repeat (6) @(posedge clk);
    #1;
    check("div4_idle", {30'd0, busy4, ser4}, 32'd0);

    check("q_drained", 32'(q.size()), 32'd0);
    check("q4_drained", 32'(q4.size()), 32'd0);
  endtask

  initial begin
    fork
      mon1();
      mon4();
      main_seq();
    join_any
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #(200000 * CLK_P);
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
